// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder stage.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH so it never wraps mid-operation.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full-adder cell driven by the serial adder controller.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first through one full-adder cell, carry recirculated in a flop.
// Define SERIAL_ADDER_B2B_EN to allow a new operand set to be accepted in the DONE cycle.
//
// state | meaning
// IDLE  | waiting for an operand handshake
// SHIFT | one bit pair per edge through the full-adder cell
// DONE  | result presented, held until out_ready
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;
    logic             load, last;

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Concatenate-then-shift keeps the WIDTH=1 case free of reversed slices.
    assign sum_nx = WIDTH'({fa_sum, sum_sh} >> 1);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_B2B_EN
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE: begin
                if (load)           state_nx = SHIFT;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else if (load) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            sum_sh <= '0;
            carry  <= cin_in;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nx;
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum_out  <= sum_nx;
                cout_out <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    logic [1:0] fa_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    logic [7:0] opa  [4] = '{8'h01, 8'h80, 8'h12, 8'hAA};
    logic [7:0] opb  [4] = '{8'h02, 8'h80, 8'h34, 8'h55};
    logic       opc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exps [4] = '{8'h03, 8'h00, 8'h47, 8'hFF};
    logic       expc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a_in      (a8),
        .b_in      (b8),
        .cin_in    (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum_out   (sum8),
        .cout_out  (cout8),
        .busy      (busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a1),
        .b_in      (b1),
        .cin_in    (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum1),
        .cout_out  (cout1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string tag);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1; out_ready8 = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
        @(negedge clk);
        in_valid8 = 1'b0; a8 = ~a; b8 = 8'h5C; cin8 = ~c;
        chk({tag, "_busy_shift"}, 32'(busy8), 32'd1);
        chk({tag, "_in_ready_shift"}, 32'(in_ready8), 32'd0);
        n = 0;
        while (out_valid8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(sum8), 32'(es));
        chk({tag, "_cout"}, 32'(cout8), 32'(ec));
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid8), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int n, sent, got, last_rise, gap_exp, extra;
        bit acc_pending, saw_valid;

`ifdef SERIAL_ADDER_B2B_EN
        gap_exp = 9;
`else
        gap_exp = 10;
`endif

        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold_no_hs", 32'(busy8), 32'd0);

        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "t1");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");

        // Backpressure: 9C+E2 = 17E, held while out_ready is low.
        @(negedge clk);
        a8 = 8'h9C; b8 = 8'hE2; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (out_valid8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 32'(n), 32'd8);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid8), 32'd1);
            chk("bp_sum", 32'(sum8), 32'h7E);
            chk("bp_cout", 32'(cout8), 32'd1);
            chk("bp_in_ready", 32'(in_ready8), 32'd0);
            chk("bp_busy", 32'(busy8), 32'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid8), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready8), 32'd1);
        chk("bp_release_busy", 32'(busy8), 32'd0);

        // Reset mid-SHIFT after three bits.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid8), 32'd0);
        chk("arst_sum", 32'(sum8), 32'd0);
        chk("arst_cout", 32'(cout8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_in_ready", 32'(in_ready8), 32'd1);
        #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid8 === 1'b1) saw_valid = 1'b1;
        end
        chk("arst_no_partial", 32'(saw_valid), 32'd0);
        run8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "t4");

        // WIDTH=1 exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); in_valid1 = 1'b1; out_ready1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            n = 0;
            while (out_valid1 !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("w1_latency_%0d", i), 32'(n), 32'd1);
            chk($sformatf("w1_result_%0d", i), 32'({cout1, sum1}), 32'(fa_tt[i]));
            @(negedge clk);
        end

        // Streaming: in_valid and out_ready held high for four operations.
        @(negedge clk);
        sent = 0; got = 0; last_rise = 0; acc_pending = 1'b0;
        a8 = opa[0]; b8 = opb[0]; cin8 = opc[0]; in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
            acc_pending = (in_ready8 === 1'b1) && (in_valid8 === 1'b1);
            @(negedge clk);
            if (acc_pending) begin
                sent++;
                if (sent < 4) begin
                    a8 = opa[sent]; b8 = opb[sent]; cin8 = opc[sent];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
            if (out_valid8 === 1'b1) begin
                chk($sformatf("stream_sum_%0d", got), 32'(sum8), 32'(exps[got]));
                chk($sformatf("stream_cout_%0d", got), 32'(cout8), 32'(expc[got]));
                if (got > 0)
                    chk($sformatf("stream_gap_%0d", got), 32'(cyc + 1 - last_rise), 32'(gap_exp));
                last_rise = cyc + 1;
                got++;
            end
        end
        chk("stream_count", 32'(got), 32'd4);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid8 === 1'b1) extra++;
        end
        chk("stream_no_extra", 32'(extra), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
